// File: rtl/spi_device_router_pkg.sv
// Shared constants and FSM encoding for the SPI device router.
// Header layout: id in bits [7:5], remaining bits ignored.
package spi_device_router_pkg;
   localparam logic [2:0] ID_STATUS = 3'd7;
   localparam int         HDR_BITS  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_FWD,
      ST_STAT,
      ST_DROP
   } state_e;
endpackage

// File: rtl/spi_device_router_pin_sync.sv
// Synchronizes sclk/ncs/di into clk and flags edges; SYNC_STAGES+1 clk to an edge pulse.
// No backpressure; edges are suppressed until both compared samples hold real pin data.
module spi_pin_sync
   import spi_device_router_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic nreset_i,
   input  logic sclk_i,
   input  logic ncs_i,
   input  logic di_i,
   output logic sclk_rise_o,
   output logic sclk_fall_o,
   output logic ncs_fall_o,
   output logic ncs_rise_o,
   output logic di_s_o
);
   logic [SYNC_STAGES-1:0] sclk_sq, ncs_sq, di_sq;
   logic                   sclk_pq, ncs_pq;
   logic [SYNC_STAGES:0]   fill_q;
   logic                   sclk_s, ncs_s, ok;

   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         sclk_sq <= '0;
         ncs_sq  <= '1;
         di_sq   <= '0;
         sclk_pq <= 1'b0;
         ncs_pq  <= 1'b1;
         fill_q  <= '0;
      end else begin
         sclk_sq <= SYNC_STAGES'({sclk_sq, sclk_i});
         ncs_sq  <= SYNC_STAGES'({ncs_sq, ncs_i});
         di_sq   <= SYNC_STAGES'({di_sq, di_i});
         sclk_pq <= sclk_s;
         ncs_pq  <= ncs_s;
         fill_q  <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // A pin held low across reset must not look like a fresh ncs falling edge.
   assign ok          = fill_q[SYNC_STAGES];
   assign sclk_s      = sclk_sq[SYNC_STAGES-1];
   assign ncs_s       = ncs_sq[SYNC_STAGES-1];
   assign sclk_rise_o = ok &  sclk_s & ~sclk_pq;
   assign sclk_fall_o = ok & ~sclk_s &  sclk_pq;
   assign ncs_fall_o  = ok & ~ncs_s  &  ncs_pq;
   assign ncs_rise_o  = ok &  ncs_s  & ~ncs_pq;
   assign di_s_o      = di_sq[SYNC_STAGES-1];
endmodule

// File: rtl/spi_device_router.sv
// Host SPI header decode -> one handler chip select, MISO mux, status byte and RR irq arbitration.
// dev_ncs asserts SYNC_STAGES+1 clk after the synchronized 8th header bit; host sclk is never stalled.
module spi_device_router
   import spi_device_router_pkg::*;
#(
   parameter int NDEV        = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk_i,
   input  logic            nreset_i,
   input  logic            sclk_i,
   input  logic            ncs_i,
   input  logic            di_i,
   output logic            do_o,
   output logic [NDEV-1:0] dev_ncs_o,
   input  logic [NDEV-1:0] dev_do_i,
   input  logic [NDEV-1:0] dev_req_i,
   output logic            nirq_o
);
   logic sclk_rise, sclk_fall, ncs_fall, ncs_rise, di_s;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i      (clk_i),
      .nreset_i   (nreset_i),
      .sclk_i     (sclk_i),
      .ncs_i      (ncs_i),
      .di_i       (di_i),
      .sclk_rise_o(sclk_rise),
      .sclk_fall_o(sclk_fall),
      .ncs_fall_o (ncs_fall),
      .ncs_rise_o (ncs_rise),
      .di_s_o     (di_s)
   );

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [2:0]      hdr_q, hdr_d;
   logic [1:0]      sel_q, sel_d;
   logic [7:0]      sh_q, sh_d;
   logic [1:0]      rr_q, rr_d, gnt_q, gnt_d;
   logic            any_q, any_d;
   logic [NDEV-1:0] dev_ncs_q, dev_ncs_d;
   logic            nirq_q;

   logic [3:0] pend4, dev_do4;
   logic [2:0] idx, rr_inc;
   logic [1:0] grant;
   logic       found;

   // Round-robin search starting at rr_q, wrapping at NDEV.
   always_comb begin
      pend4 = 4'(dev_req_i);
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NDEV; k++) begin
         idx = {1'b0, rr_q} + 3'(k);
         if (idx >= 3'(NDEV)) idx = idx - 3'(NDEV);
         if (!found && pend4[idx[1:0]]) begin
            found = 1'b1;
            grant = idx[1:0];
         end
      end
      rr_inc = {1'b0, gnt_q} + 3'd1;
      if (rr_inc >= 3'(NDEV)) rr_inc = 3'd0;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hdr_d   = hdr_q;
      sel_d   = sel_q;
      sh_d    = sh_q;
      rr_d    = rr_q;
      gnt_d   = gnt_q;
      any_d   = any_q;
      if (ncs_rise) begin
         state_d = ST_IDLE;
         sh_d    = 8'hFF;
         if (state_q == ST_STAT && cnt_q == 4'(HDR_BITS) && any_q) rr_d = rr_inc[1:0];
      end else begin
         case (state_q)
            ST_IDLE: if (ncs_fall) begin
               state_d = ST_HDR;
               cnt_d   = '0;
            end
            ST_HDR: if (sclk_rise) begin
               // Only the id bits are kept; the rest of the header is dropped.
               if (cnt_q < 4'd3) hdr_d = {hdr_q[1:0], di_s};
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'(HDR_BITS - 1)) begin
                  cnt_d = '0;
                  if (hdr_q < 3'(NDEV)) begin
                     state_d = ST_FWD;
                     sel_d   = hdr_q[1:0];
                  end else if (hdr_q == ID_STATUS) begin
                     state_d = ST_STAT;
                     sh_d    = {found, 1'b0, grant, pend4};
                     gnt_d   = grant;
                     any_d   = found;
                  end else begin
                     state_d = ST_DROP;
                  end
               end
            end
            ST_STAT: begin
               // cnt counts status bits sampled by the host; the header's own falling edge is skipped.
               if (sclk_rise && cnt_q != 4'(HDR_BITS)) cnt_d = cnt_q + 4'd1;
               if (sclk_fall && cnt_q != 4'd0) sh_d = {sh_q[6:0], 1'b1};
            end
            ST_FWD, ST_DROP: ;
            default: state_d = ST_IDLE;
         endcase
      end
      for (int i = 0; i < NDEV; i++)
         dev_ncs_d[i] = !((state_d == ST_FWD) && (sel_d == 2'(i)));
   end

   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hdr_q     <= '0;
         sel_q     <= '0;
         sh_q      <= 8'hFF;
         rr_q      <= '0;
         gnt_q     <= '0;
         any_q     <= 1'b0;
         dev_ncs_q <= '1;
         nirq_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hdr_q     <= hdr_d;
         sel_q     <= sel_d;
         sh_q      <= sh_d;
         rr_q      <= rr_d;
         gnt_q     <= gnt_d;
         any_q     <= any_d;
         dev_ncs_q <= dev_ncs_d;
         nirq_q    <= ~|dev_req_i;
      end
   end

   assign dev_do4   = 4'(dev_do_i);
   assign do_o      = (state_q == ST_FWD) ? dev_do4[sel_q] : sh_q[7];
   assign dev_ncs_o = dev_ncs_q;
   assign nirq_o    = nirq_q;
endmodule

// File: tb/tb_spi_device_router.sv
// Directed host-SPI frames; a pin-level monitor assembles host-read bytes and scores them against a queue.
module tb_spi_device_router;
   logic       clk_i = 1'b0;
   logic       nreset_i, sclk_i, ncs_i, di_i, do_o, nirq_o;
   logic [2:0] dev_ncs_o, dev_do_i, dev_req_i;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   always #5 clk_i = ~clk_i;

   spi_device_router #(.NDEV(3), .SYNC_STAGES(2)) dut (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .sclk_i   (sclk_i),
      .ncs_i    (ncs_i),
      .di_i     (di_i),
      .do_o     (do_o),
      .dev_ncs_o(dev_ncs_o),
      .dev_do_i (dev_do_i),
      .dev_req_i(dev_req_i),
      .nirq_o   (nirq_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Host-side monitor: one byte per 8 sclk rises inside a frame.
   initial begin : monitor
      logic [7:0] rx;
      logic [7:0] e;
      int         nb;
      rx = '0;
      nb = 0;
      forever begin
         @(posedge sclk_i or negedge ncs_i);
         if (sclk_i === 1'b1 && ncs_i === 1'b0) begin
            rx = {rx[6:0], do_o};
            nb++;
            if (nb == 8) begin
               nb = 0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL host_byte: got %0h with no byte expected", rx);
               end else begin
                  e = exp_q.pop_front();
                  chk("host_byte", 32'(rx), 32'(e));
               end
            end
         end else begin
            nb = 0;
         end
      end
   end

   task automatic xfer(input logic [7:0] mosi, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         di_i     = mosi[i];
         dev_do_i = {d2[i], d1[i], d0[i]};
         repeat (8) @(negedge clk_i);
         sclk_i = 1'b1;
         repeat (8) @(negedge clk_i);
         sclk_i = 1'b0;
      end
   endtask

   task automatic frame_begin();
      @(negedge clk_i);
      ncs_i = 1'b0;
      repeat (8) @(negedge clk_i);
   endtask

   task automatic frame_end();
      repeat (8) @(negedge clk_i);
      ncs_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("dev_ncs_after_ncs_rise", 32'(dev_ncs_o), 32'h7);
      repeat (12) @(negedge clk_i);
   endtask

   initial begin
      nreset_i  = 1'b0;
      sclk_i    = 1'b0;
      ncs_i     = 1'b1;
      di_i      = 1'b0;
      dev_do_i  = '0;
      dev_req_i = '0;
      repeat (4) @(negedge clk_i);
      chk("reset_dev_ncs", 32'(dev_ncs_o), 32'h7);
      chk("reset_do", 32'(do_o), 32'h1);
      chk("reset_nirq", 32'(nirq_o), 32'h1);
      nreset_i = 1'b1;
      repeat (6) @(negedge clk_i);

      // Forward to handler 1.
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hA5);
      frame_begin();
      xfer(8'h20, 8'h3C, 8'hA5, 8'h0F, 8);
      chk("t1_sel_hdr", 32'(dev_ncs_o), 32'h5);
      xfer(8'h00, 8'h3C, 8'hA5, 8'h0F, 8);
      chk("t1_sel_payload", 32'(dev_ncs_o), 32'h5);
      frame_end();

      // Unpopulated id 3 is dropped.
      for (int i = 0; i < 9; i++) exp_q.push_back(8'hFF);
      frame_begin();
      xfer(8'h60, 8'h00, 8'h00, 8'h00, 8);
      chk("t2_no_sel", 32'(dev_ncs_o), 32'h7);
      for (int i = 0; i < 8; i++) xfer(8'h11, 8'h00, 8'h00, 8'h00, 8);
      chk("t2_no_sel_end", 32'(dev_ncs_o), 32'h7);
      frame_end();

      // Status reads with round-robin advance.
      dev_req_i = 3'b110;
      repeat (2) @(negedge clk_i);
      chk("t3_nirq", 32'(nirq_o), 32'h0);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h96);
      frame_begin();
      xfer(8'hE0, 8'h00, 8'h00, 8'h00, 8);
      xfer(8'hFF, 8'h00, 8'h00, 8'h00, 8);
      frame_end();
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hA6);
      frame_begin();
      xfer(8'hE0, 8'h00, 8'h00, 8'h00, 8);
      xfer(8'hFF, 8'h00, 8'h00, 8'h00, 8);
      frame_end();

      // Partial header is discarded.
      dev_req_i = 3'b000;
      repeat (2) @(negedge clk_i);
      chk("t4_nirq_idle", 32'(nirq_o), 32'h1);
      frame_begin();
      xfer(8'h00, 8'h00, 8'h00, 8'h00, 5);
      repeat (8) @(negedge clk_i);
      chk("t4_partial_no_sel", 32'(dev_ncs_o), 32'h7);
      frame_end();
      exp_q.push_back(8'hFF);
      frame_begin();
      xfer(8'h00, 8'h00, 8'h00, 8'h00, 8);
      chk("t4_sel0", 32'(dev_ncs_o), 32'h6);
      frame_end();

      // Aborted status reads leave rr_ptr alone.
      dev_req_i = 3'b001;
      exp_q.push_back(8'hFF);
      frame_begin();
      xfer(8'hE0, 8'h00, 8'h00, 8'h00, 8);
      xfer(8'hFF, 8'h00, 8'h00, 8'h00, 4);
      frame_end();
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h81);
      frame_begin();
      xfer(8'hE0, 8'h00, 8'h00, 8'h00, 8);
      xfer(8'hFF, 8'h00, 8'h00, 8'h00, 8);
      frame_end();
      dev_req_i = 3'b011;
      exp_q.push_back(8'hFF);
      frame_begin();
      xfer(8'hE0, 8'h00, 8'h00, 8'h00, 8);
      xfer(8'hFF, 8'h00, 8'h00, 8'h00, 4);
      frame_end();
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h93);
      frame_begin();
      xfer(8'hE0, 8'h00, 8'h00, 8'h00, 8);
      xfer(8'hFF, 8'h00, 8'h00, 8'h00, 8);
      frame_end();

      // Reset in the middle of a forwarded frame.
      dev_req_i = 3'b000;
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h3C);
      frame_begin();
      xfer(8'h40, 8'hC3, 8'h0F, 8'h3C, 8);
      xfer(8'h00, 8'hC3, 8'h0F, 8'h3C, 8);
      chk("t6_sel2", 32'(dev_ncs_o), 32'h3);
      @(negedge clk_i);
      nreset_i = 1'b0;
      @(negedge clk_i);
      chk("t6_reset_dev_ncs", 32'(dev_ncs_o), 32'h7);
      chk("t6_reset_do", 32'(do_o), 32'h1);
      nreset_i = 1'b1;
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      for (int i = 0; i < 2; i++) begin
         xfer(8'h00, 8'hC3, 8'h0F, 8'h3C, 8);
         chk("t6_no_sel_after_reset", 32'(dev_ncs_o), 32'h7);
      end
      frame_end();

      repeat (20) @(negedge clk_i);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
